// File: rtl/irq_pkg.sv
// Shared helpers for the interrupt controller: ID width, priority encoding and
// vector address arithmetic.
package irq_pkg;

  localparam int MAX_IRQ = 16;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the highest set bit, or -1 when the vector is empty.
  function automatic int hsb(input logic [MAX_IRQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [63:0] vec_addr(input logic [63:0] base, input int stride, input int id);
    return base + 64'(stride) * 64'(id);
  endfunction

endpackage

// File: rtl/irq_sync_debounce.sv
// One request line: multi-flop synchroniser, stability debounce and rise detect.
module irq_sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_deb;
  logic                   r_prev;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_deb;
  assign o_rise  = r_deb & ~r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_prev <= r_deb;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_nodeb
      always_ff @(posedge clk) begin
        if (rst) r_deb <= 1'b0;
        else     r_deb <= w_sync;
      end
    end else begin : g_deb
      localparam int CW = $clog2(DEB_CYCLES + 1);
      logic [CW-1:0] r_cnt;
      // The change is taken once DEB_CYCLES disagreeing cycles have already been counted.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
          r_deb <= 1'b0;
        end else if (w_sync == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DEB_CYCLES)) begin
          r_deb <= w_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/irq_controller.sv
// N-channel prioritised interrupt controller with nesting via an in-service
// register and a request/ack/eoi handshake to the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int                   N_IRQ       = 4,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   DEB_CYCLES  = 0,
  parameter int                   VEC_WIDTH   = 32,
  parameter logic [VEC_WIDTH-1:0] VEC_BASE    = 32'h0000_3000,
  parameter int                   VEC_STRIDE  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_IRQ-1:0]              irq_in,
  input  logic [N_IRQ-1:0]              edge_mode,
  input  logic [N_IRQ-1:0]              irq_mask,
  input  logic                          int_en,
  output logic                          irq_req,
  input  logic                          irq_ack,
  output logic [id_width(N_IRQ)-1:0]    irq_id,
  output logic [VEC_WIDTH-1:0]          irq_vec,
  input  logic                          eoi,
  output logic [N_IRQ-1:0]              isr_out,
  output logic [N_IRQ-1:0]              pending_out
);

  localparam int IDW = id_width(N_IRQ);

  logic [N_IRQ-1:0]     w_level;
  logic [N_IRQ-1:0]     w_rise;
  logic [N_IRQ-1:0]     w_eligible;
  logic [N_IRQ-1:0]     w_pending_next;
  logic [N_IRQ-1:0]     w_isr_clr;
  logic [N_IRQ-1:0]     w_isr_set;
  logic [IDW-1:0]       w_cand_id;
  logic                 w_cand_valid;
  logic                 w_accept;
  int                   w_isr_top;
  int                   w_cand_top;

  logic [N_IRQ-1:0]     r_pending;
  logic [N_IRQ-1:0]     r_isr;
  logic                 r_req;
  logic [IDW-1:0]       r_id;
  logic [VEC_WIDTH-1:0] r_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_ch
      irq_sync_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
      ) u_sd (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (irq_in[gi]),
        .o_level(w_level[gi]),
        .o_rise (w_rise[gi])
      );
    end
  endgenerate

  // Only a channel strictly above everything in service may preempt.
  assign w_eligible   = r_pending & ~irq_mask;
  assign w_isr_top    = hsb(MAX_IRQ'(r_isr));
  assign w_cand_top   = hsb(MAX_IRQ'(w_eligible));
  assign w_cand_valid = (w_cand_top >= 0) && (w_cand_top > w_isr_top);
  assign w_cand_id    = w_cand_valid ? w_cand_top[IDW-1:0] : '0;
  assign w_accept     = irq_ack & r_req & w_cand_valid;

  always_comb begin
    w_isr_clr      = '0;
    w_isr_set      = '0;
    w_pending_next = r_pending;
    if (eoi && (w_isr_top >= 0)) w_isr_clr[w_isr_top] = 1'b1;
    if (w_accept) w_isr_set[w_cand_id] = 1'b1;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!edge_mode[i])                                w_pending_next[i] = w_level[i];
      else if (w_rise[i])                               w_pending_next[i] = 1'b1;
      else if (w_accept && (w_cand_id == IDW'(i)))      w_pending_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_isr     <= '0;
      r_req     <= 1'b0;
      r_id      <= '0;
      r_vec     <= VEC_BASE;
    end else begin
      r_pending <= w_pending_next;
      r_isr     <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_req     <= w_cand_valid & int_en & ~irq_ack;
      if (w_accept) begin
        r_id  <= w_cand_id;
        r_vec <= VEC_WIDTH'(vec_addr(64'(VEC_BASE), VEC_STRIDE, int'(w_cand_id)));
      end
    end
  end

  assign irq_req     = r_req;
  assign irq_id      = r_id;
  assign irq_vec     = r_vec;
  assign isr_out     = r_isr;
  assign pending_out = r_pending;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: default instance plus a DEB_CYCLES=5 instance.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in, edge_mode, irq_mask;
  logic        int_en, irq_ack, eoi;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [31:0] irq_vec;
  logic [3:0]  isr_out, pending_out;

  logic [3:0]  irq_in_d;
  logic        irq_req_d;
  logic [1:0]  irq_id_d;
  logic [31:0] irq_vec_d;
  logic [3:0]  isr_out_d, pending_out_d;
  logic        ack_d = 1'b0;
  logic        eoi_d = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_controller dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode), .irq_mask(irq_mask),
    .int_en(int_en), .irq_req(irq_req), .irq_ack(irq_ack), .irq_id(irq_id),
    .irq_vec(irq_vec), .eoi(eoi), .isr_out(isr_out), .pending_out(pending_out)
  );

  irq_controller #(.DEB_CYCLES(5)) dut_deb (
    .clk(clk), .rst(rst), .irq_in(irq_in_d), .edge_mode(edge_mode), .irq_mask(irq_mask),
    .int_en(int_en), .irq_req(irq_req_d), .irq_ack(ack_d), .irq_id(irq_id_d),
    .irq_vec(irq_vec_d), .eoi(eoi_d), .isr_out(isr_out_d), .pending_out(pending_out_d)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; irq_in_d = '0; edge_mode = 4'hF; irq_mask = '0;
    int_en = 1'b1; irq_ack = 1'b0; eoi = 1'b0;
    tick(2);
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_vec", irq_vec, 32'h3000);
    check("rst_isr", 32'(isr_out), 32'd0);
    check("rst_pend", 32'(pending_out), 32'd0);

    // Edge-mode 3-cycle pulse on ch1: request 4 clocks after first sample
    rst = 1'b0; irq_in = 4'b0010;
    tick(3); irq_in = 4'b0000;
    tick(1); check("lat_req_early", 32'(irq_req), 32'd0);
    tick(1); check("lat_req", 32'(irq_req), 32'd1);
    pulse_ack();
    check("t1_id", 32'(irq_id), 32'd1);
    check("t1_vec", irq_vec, 32'h3004);
    check("t1_isr", 32'(isr_out), 32'b0010);
    check("t1_pend", 32'(pending_out), 32'd0);
    check("t1_req_drop", 32'(irq_req), 32'd0);
    pulse_eoi();
    check("t1_eoi", 32'(isr_out), 32'd0);
    pulse_eoi();
    check("t1_eoi_idle", 32'(isr_out), 32'd0);

    // Simultaneous ch0 and ch2: ch2 wins, ch0 blocked until eoi
    irq_in = 4'b0101;
    tick(5); check("t2_req", 32'(irq_req), 32'd1);
    pulse_ack();
    check("t2_id", 32'(irq_id), 32'd2);
    check("t2_isr", 32'(isr_out), 32'b0100);
    check("t2_pend", 32'(pending_out), 32'b0001);
    irq_in = 4'b0000;
    tick(3); check("t2_blocked", 32'(irq_req), 32'd0);
    pulse_eoi();
    check("t2_eoi", 32'(isr_out), 32'd0);
    tick(); check("t2_rereq", 32'(irq_req), 32'd1);
    pulse_ack();
    check("t2_id0", 32'(irq_id), 32'd0);
    check("t2_vec0", irq_vec, 32'h3000);
    check("t2_isr0", 32'(isr_out), 32'b0001);
    pulse_eoi();

    // Nesting: ch3 preempts ch1
    irq_in = 4'b0010;
    tick(5); pulse_ack();
    check("t3_isr1", 32'(isr_out), 32'b0010);
    irq_in = 4'b1010;
    tick(4); check("t3_req_early", 32'(irq_req), 32'd0);
    tick(1); check("t3_req", 32'(irq_req), 32'd1);
    pulse_ack();
    check("t3_id", 32'(irq_id), 32'd3);
    check("t3_vec", irq_vec, 32'h300C);
    check("t3_isr", 32'(isr_out), 32'b1010);
    pulse_eoi(); check("t3_eoi1", 32'(isr_out), 32'b0010);
    pulse_eoi(); check("t3_eoi2", 32'(isr_out), 32'b0000);
    irq_in = 4'b0000;
    tick(4);

    // Level mode on ch2
    edge_mode = 4'b1011; irq_in = 4'b0100;
    tick(5); check("t4_req", 32'(irq_req), 32'd1);
    pulse_ack();
    check("t4_isr", 32'(isr_out), 32'b0100);
    check("t4_pend_kept", 32'(pending_out), 32'b0100);
    tick(); check("t4_req_low", 32'(irq_req), 32'd0);
    pulse_eoi();
    check("t4_req_at_eoi", 32'(irq_req), 32'd0);
    tick(); check("t4_rereq", 32'(irq_req), 32'd1);
    irq_mask = 4'b0100;
    tick(); check("t4_mask_req", 32'(irq_req), 32'd0);
    check("t4_mask_pend", 32'(pending_out), 32'b0100);
    irq_in = 4'b0000;
    tick(6); irq_mask = 4'b0000;
    tick(); check("t4_deassert_req", 32'(irq_req), 32'd0);
    check("t4_deassert_pend", 32'(pending_out), 32'd0);
    edge_mode = 4'hF;

    // Debounce instance: glitch rejected, long pulse accepted
    irq_in_d = 4'b0001;
    tick(3); irq_in_d = 4'b0000;
    tick(12); check("t5_glitch", 32'(pending_out_d), 32'd0);
    irq_in_d = 4'b0001;
    tick(8); irq_in_d = 4'b0000;
    tick(4); check("t5_pulse", 32'(pending_out_d), 32'b0001);

    // Same-cycle eoi+ack, then reset during service
    irq_in = 4'b0010;
    tick(5); pulse_ack();
    irq_in = 4'b1010;
    tick(5); check("t6_req", 32'(irq_req), 32'd1);
    irq_ack = 1'b1; eoi = 1'b1; tick(); irq_ack = 1'b0; eoi = 1'b0;
    check("t6_isr", 32'(isr_out), 32'b1000);
    check("t6_id", 32'(irq_id), 32'd3);
    rst = 1'b1; tick();
    check("t6_rst_req", 32'(irq_req), 32'd0);
    check("t6_rst_id", 32'(irq_id), 32'd0);
    check("t6_rst_vec", irq_vec, 32'h3000);
    check("t6_rst_isr", 32'(isr_out), 32'd0);
    check("t6_rst_pend", 32'(pending_out), 32'd0);
    rst = 1'b0;
    tick(5);
    check("t6_held_req", 32'(irq_req), 32'd1);
    check("t6_held_pend", 32'(pending_out), 32'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt controller between the board's raw request sources (buttons) and the pipelined CPU core; N-channel generalisation of the fixed 3-line IRQ/IRW scheme.
- Per channel: synchronise and debounce, latch in edge or level mode, mask.
- Prioritises channels and supports nested interrupts through an in-service register.
- CPU handshake is request/acknowledge/end-of-interrupt; the block returns a vector address and drives in-service LEDs (IRW).

Parameters:
N_IRQ, 4, number of interrupt channels (2..16)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEB_CYCLES, 0, consecutive stable cycles before an input change is accepted (0 = no debounce; board builds use ~1_000_000)
VEC_WIDTH, 32, vector output width
VEC_BASE, 32'h0000_3000, vector of channel 0
VEC_STRIDE, 4, byte spacing between channel vectors

Ports:
clk  in  1  system clock (CPU clock domain)
rst  in  1  synchronous reset, active-high
irq_in  in  N_IRQ  raw asynchronous request lines
edge_mode  in  N_IRQ  per channel: 1 = rising-edge latched, 0 = level
irq_mask  in  N_IRQ  per channel: 1 = masked
int_en  in  1  global interrupt enable from CPU
irq_req  out  1  registered interrupt request to CPU
irq_ack  in  1  one-cycle acknowledge from CPU
irq_id  out  clog2(N_IRQ)  channel accepted at last ack
irq_vec  out  VEC_WIDTH  VEC_BASE + irq_id*VEC_STRIDE
eoi  in  1  one-cycle end-of-interrupt (return from handler)
isr_out  out  N_IRQ  in-service register (IRW LEDs)
pending_out  out  N_IRQ  pending register

Behaviour:
- Reset: synchroniser, debounce counters, debounced values, previous-value registers, pending and isr are cleared; irq_req=0, irq_id=0, irq_vec=VEC_BASE. Reset mid-handler discards all nesting state. An input held high through reset produces one rising edge after release.
- Debounce, per channel: a counter counts consecutive cycles where the synchronised input differs from the debounced value. At DEB_CYCLES the debounced value takes the synchronised input and the counter clears. Any agreement in between clears the counter. DEB_CYCLES=0: the debounced value copies the synchronised input every cycle.
- Pending, edge mode: set when debounced & ~prev_debounced. Cleared on ack of that channel. If set and clear land on the same cycle, set wins.
- Pending, level mode: equals the debounced value. It is never cleared by ack; the handler must deassert the source.
- Priority: higher index = higher priority. Candidate = highest bit of pending & ~irq_mask whose index is above the highest set isr bit; none while any higher-or-equal isr bit is set.
- irq_req is registered and equals (candidate exists) & int_en & ~irq_ack from the previous cycle. It drops the cycle after ack.
- Latency: irq_req rises SYNC_STAGES+DEB_CYCLES+2 clocks after the first edge that samples irq_in high; 4 with defaults.
- Ack while irq_req=1 latches the candidate into irq_id/irq_vec, sets isr[id] and clears pending[id] (edge mode). irq_id/irq_vec hold until the next accepted ack. Ack while irq_req=0 is ignored.
- eoi clears the highest set isr bit; eoi with isr=0 is ignored.
- eoi and ack in the same cycle: eoi clears first, then ack sets the new bit. Both take effect.
- Nesting depth is bounded by N_IRQ. Masking a channel that is already in service does not clear its isr bit.

Decomposition:
- Package irq_pkg: clog2-based ID width function, highest-set-bit priority-encoder function, vector computation function.
- Sub-module irq_sync_debounce: per channel, parameters SYNC_STAGES and DEB_CYCLES, outputs debounced level and rise pulse. Generated N_IRQ times.

Test Plan:
- Defaults, edge mode, mask=0, int_en=1; pulse irq_in[1] high for 3 cycles -> irq_req high exactly 4 clocks after first sample. Ack -> irq_id=1, irq_vec=32'h3004, isr_out=4'b0010, pending_out=0.
- irq_in[0] and irq_in[2] rise in the same cycle -> first ack gives id=2. With isr=4'b0100, id=0 is not requested. After eoi -> isr=0, irq_req rises, ack gives id=0, vec=32'h3000.
- Nesting: in service on id=1, raise irq_in[3] -> ack gives id=3, isr=4'b1010. First eoi -> 4'b0010; second eoi -> 4'b0000.
- Level mode ch2 held high: ack then eoi -> irq_req reasserts 1 cycle after eoi. Deassert input -> no further request. Mask ch2 while high -> irq_req=0, pending_out[2]=1.
- DEB_CYCLES=5: 3-cycle glitch on irq_in[0] -> no pending. 8-cycle pulse -> pending set. Same-cycle eoi+ack and rst asserted during service -> every output at its reset value the next cycle.
